// File: rtl/alu_sequencer_if.sv
// Handshake and control bundle between an instruction source and the ALU sequencer.
interface alu_sequencer_if;
  logic       Exec;
  logic [9:0] INSTR;
  logic [3:0] FN;
  logic       Ain;
  logic       Gin;
  logic       Gout;
  logic [3:0] Rin;
  logic [3:0] Rout;
  logic       Extern;
  logic       Busy;
  logic       Done;
  logic       Err;

  // Instruction source side: issues requests, observes the control strobes.
  modport master (
    output Exec, INSTR,
    input  FN, Ain, Gin, Gout, Rin, Rout, Extern, Busy, Done, Err
  );

  // Sequencer side: accepts requests, drives the control strobes.
  modport slave (
    input  Exec, INSTR,
    output FN, Ain, Gin, Gout, Rin, Rout, Extern, Busy, Done, Err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer for a 4-register datapath with a shared bus and one ALU.
// Binary ops take T1..T3, unary ops T2..T3, unsupported codes a single ERR cycle.
// All state changes on the falling edge of CLKb.
module alu_sequencer (
  input logic            CLKb,
  input logic            Clear,
  alu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StT1, StT2, StT3, StErr} state_e;

  state_e     state_q, state_d;
  logic [9:0] ir_q, ir_d;

  logic [3:0] fn;
  logic [1:0] rx;
  logic [1:0] ry;
  logic [3:0] rx_oh;
  logic [3:0] ry_oh;

  assign fn    = ir_q[9:6];
  assign rx    = ir_q[5:4];
  assign ry    = ir_q[3:2];
  assign rx_oh = 4'b0001 << rx;
  assign ry_oh = 4'b0001 << ry;

  // Low IR bits carry no meaning but are kept so IR mirrors the full instruction.
  logic unused_ir;
  assign unused_ir = ^ir_q[1:0];

  // Binary ops need operand A staged in Temp first, so they enter at T1.
  function automatic logic is_binary(input logic [3:0] code);
    case (code)
      4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1000: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  // State and instruction register, synchronous clear.
  always_ff @(negedge CLKb) begin
    if (Clear) begin
      state_q <= StIdle;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state: accept only in IDLE, then walk the fixed step sequence.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Exec) begin
          ir_d = bus.INSTR;
          if (bus.INSTR[9:8] == 2'b11) begin
            state_d = StErr;
          end else if (is_binary(bus.INSTR[9:6])) begin
            state_d = StT1;
          end else begin
            state_d = StT2;
          end
        end
      end
      StT1:    state_d = StT2;
      StT2:    state_d = StT3;
      StT3:    state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: decoded from state and IR only, never from the live request inputs.
  always_comb begin
    bus.FN     = 4'b0000;
    bus.Ain    = 1'b0;
    bus.Gin    = 1'b0;
    bus.Gout   = 1'b0;
    bus.Rin    = 4'b0000;
    bus.Rout   = 4'b0000;
    bus.Extern = 1'b0;
    bus.Busy   = 1'b0;
    bus.Done   = 1'b0;
    bus.Err    = 1'b0;
    unique case (state_q)
      StIdle: ;
      StT1: begin
        bus.FN   = fn;
        bus.Busy = 1'b1;
        bus.Rout = ry_oh;
        bus.Ain  = 1'b1;
      end
      StT2: begin
        bus.FN   = fn;
        bus.Busy = 1'b1;
        bus.Gin  = 1'b1;
        // Load takes its operand from the external bus; everything else from Rx.
        if (fn == 4'b0000) begin
          bus.Extern = 1'b1;
        end else begin
          bus.Rout = rx_oh;
        end
      end
      StT3: begin
        bus.FN   = fn;
        bus.Busy = 1'b1;
        bus.Gout = 1'b1;
        bus.Rin  = rx_oh;
        bus.Done = 1'b1;
      end
      StErr: begin
        bus.FN   = fn;
        bus.Busy = 1'b1;
        bus.Done = 1'b1;
        bus.Err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
